// File: rtl/tl_traffic_gen.sv
// tl_traffic_gen -- traffic generator and checker for the transaction-layer
// FIFO/arbiter path.
//
// A run programs two threshold pairs into the FIFOs (init high for two
// cycles). It then pushes WORDS class-tagged words per class into the input
// FIFO. A per-class output FIFO is popped only when it reports almost-full,
// or once every word has been pushed. Each popped word is checked for class
// routing and per-class order. The result is reported through
// done/pass/timeout/err_cnt.
//
// Word format: [CLASS_LSB+CLASS_W-1:CLASS_LSB] = class, [CLASS_LSB-1:0] =
// per-class sequence number, all other bits zero.
//
// Ports:
//   clk, reset_L              clock (rising edge), async active-low reset
//   start                     one-cycle pulse; accepted only in IDLE or DONE
//   init, umbral_bajo/alto    FIFO configuration mode and thresholds
//   push, data_out, in_full   input-FIFO write side (registered)
//   pop, almost_full, empty   per-class output-FIFO read control
//   data_in, valid            per-class read data, valid one cycle after pop
//   done, pass, timeout       run status (sticky until the next start)
//   err_cnt                   saturating mismatch count
module tl_traffic_gen #(
  parameter int DATA_W    = 12,
  parameter int CLASS_W   = 2,
  parameter int CLASS_LSB = 8,
  parameter int WORDS     = 4,
  parameter int THR_W     = 3,
  parameter int THR_LO0   = 0,
  parameter int THR_HI0   = 7,
  parameter int THR_LO1   = 1,
  parameter int THR_HI1   = 6,
  parameter int TIMEOUT   = 64
) (
  input  logic                               clk,
  input  logic                               reset_L,
  input  logic                               start,
  output logic                               init,
  output logic [THR_W-1:0]                   umbral_bajo,
  output logic [THR_W-1:0]                   umbral_alto,
  output logic                               push,
  output logic [DATA_W-1:0]                  data_out,
  input  logic                               in_full,
  output logic [(1<<CLASS_W)-1:0]            pop,
  input  logic [(1<<CLASS_W)-1:0]            almost_full,
  input  logic [(1<<CLASS_W)-1:0]            empty,
  input  logic [(1<<CLASS_W)*DATA_W-1:0]     data_in,
  input  logic [(1<<CLASS_W)-1:0]            valid,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic [7:0]                         err_cnt
);

  localparam int N      = 1 << CLASS_W;
  localparam int SEQ_W  = CLASS_LSB;
  localparam int RCV_W  = CLASS_LSB + 1;        // must hold WORDS itself
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG0, S_CFG1, S_REL, S_RUN, S_DONE
  } state_t;

  state_t             state;
  logic [CLASS_W-1:0] push_cls;     // class of the next word to push
  logic [SEQ_W-1:0]   push_seq;     // sequence of the next word to push
  logic               all_pushed;
  logic [N-1:0]       pend;         // pop issued last cycle: valid expected now
  logic [RCV_W-1:0]   rcv     [N];  // words received per class
  logic [SEQ_W-1:0]   exp_seq [N];  // next expected sequence per class
  logic [IDLE_W-1:0]  idle_cnt;     // consecutive cycles without progress

  function automatic logic [DATA_W-1:0] make_word(input logic [CLASS_W-1:0] c,
                                                  input logic [SEQ_W-1:0]   s);
    logic [DATA_W-1:0] w;
    w                        = '0;
    w[CLASS_LSB +: CLASS_W]  = c;
    w[SEQ_W-1:0]             = s;
    return w;
  endfunction

  logic [N-1:0] pop_sel;
  logic [7:0]   err_next;
  logic         rcv_all;
  logic         activity;
  logic         run_finish;
  logic         run_timeout;
  logic         leave_run;
  logic         push_go;

  // NOTE: every variable gets a default at the top of the always_comb so no
  // path leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    pop_sel = '0;
    // Walk from the top down so the lowest eligible class is the one kept.
    // A pop already in flight counts against the class budget so the FIFO
    // is never popped for more than WORDS words.
    for (int k = N - 1; k >= 0; k--) begin
      if (!empty[k] && (almost_full[k] || all_pushed) &&
          (({1'b0, rcv[k]} + {{RCV_W{1'b0}}, pend[k]}) < (RCV_W + 1)'(WORDS))) begin
        pop_sel    = '0;
        pop_sel[k] = 1'b1;
      end
    end

    // A valid outside RUN, or without a pop one cycle earlier, is an error
    // by itself; otherwise the word is compared against {class, exp_seq}.
    err_next = err_cnt;
    for (int k = 0; k < N; k++) begin
      if (valid[k] && ((state != S_RUN) || !pend[k] ||
          (data_in[k*DATA_W +: DATA_W] != make_word(CLASS_W'(k), exp_seq[k])))) begin
        if (err_next != 8'hFF) err_next = err_next + 8'd1;
      end
    end

    rcv_all = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (rcv[k] != RCV_W'(WORDS)) rcv_all = 1'b0;
    end

    activity    = push || (pop != '0) || (valid != '0);
    run_finish  = (state == S_RUN) && rcv_all && (pend == '0) && (pop == '0);
    run_timeout = (state == S_RUN) && !activity && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    leave_run   = run_finish || run_timeout;
    // Pushing starts on the edge leaving REL so the first word is visible in
    // the first RUN cycle.
    push_go     = ((state == S_REL) || ((state == S_RUN) && !leave_run)) &&
                  !in_full && !all_pushed;
  end

  // NOTE: state is written only with non-blocking assignments; when a later
  // assignment in this block targets the same register (e.g. the clears on
  // start), the later one wins.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= S_IDLE;
      init        <= 1'b0;
      umbral_bajo <= '0;
      umbral_alto <= '0;
      push        <= 1'b0;
      data_out    <= '0;
      pop         <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      err_cnt     <= '0;
      push_cls    <= '0;
      push_seq    <= '0;
      all_pushed  <= 1'b0;
      pend        <= '0;
      idle_cnt    <= '0;
      // NOTE: these per-class arrays are control counters, not storage, so
      // they are reset along with the rest of the state.
      for (int k = 0; k < N; k++) begin
        rcv[k]     <= '0;
        exp_seq[k] <= '0;
      end
    end else begin
      pend    <= pop;
      push    <= push_go;
      pop     <= '0;
      err_cnt <= err_next;

      if (push_go) begin
        data_out <= make_word(push_cls, push_seq);
        if (push_seq == SEQ_W'(WORDS - 1)) begin
          push_seq <= '0;
          if (push_cls == CLASS_W'(N - 1)) all_pushed <= 1'b1;
          else                             push_cls   <= push_cls + CLASS_W'(1);
        end else begin
          push_seq <= push_seq + SEQ_W'(1);
        end
      end

      // Expected sequence advances on every accepted word, match or not.
      for (int k = 0; k < N; k++) begin
        if ((state == S_RUN) && valid[k] && pend[k]) begin
          exp_seq[k] <= exp_seq[k] + SEQ_W'(1);
          rcv[k]     <= rcv[k] + RCV_W'(1);
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_CFG0;
            init        <= 1'b1;
            umbral_bajo <= THR_W'(THR_LO0);
            umbral_alto <= THR_W'(THR_HI0);
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            err_cnt     <= '0;
            push_cls    <= '0;
            push_seq    <= '0;
            all_pushed  <= 1'b0;
            idle_cnt    <= '0;
            for (int k = 0; k < N; k++) begin
              rcv[k]     <= '0;
              exp_seq[k] <= '0;
            end
          end
        end
        S_CFG0: begin
          state       <= S_CFG1;
          umbral_bajo <= THR_W'(THR_LO1);
          umbral_alto <= THR_W'(THR_HI1);
        end
        S_CFG1: begin
          state <= S_REL;
          init  <= 1'b0;
        end
        S_REL: begin
          state    <= S_RUN;
          idle_cnt <= '0;
        end
        S_RUN: begin
          // No pop right after a pop: the FIFO's empty flag does not yet
          // reflect the previous read.
          if (!leave_run && (pop == '0)) pop <= pop_sel;
          idle_cnt <= activity ? '0 : idle_cnt + IDLE_W'(1);
          if (run_finish) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
          end else if (run_timeout) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_traffic_gen.sv
// Bench for tl_traffic_gen. A behavioural model of the FIFO path (ideal
// per-class queues with optional class swap, suppressed valid, random or
// forced input-full) feeds the generator. The model checks every cycle:
// push order, push flow control, data hold, and pop legality. After each
// run it compares the final status with the model's error count.
module tb_tl_traffic_gen;

  localparam int DATA_W    = 12;
  localparam int CLASS_W   = 2;
  localparam int CLASS_LSB = 8;
  localparam int WORDS     = 4;
  localparam int THR_W     = 3;
  localparam int TIMEOUT   = 64;
  localparam int N         = 1 << CLASS_W;
  localparam int TOTAL     = N * WORDS;

  logic                   clk = 1'b0;
  logic                   reset_L;
  logic                   start;
  logic                   init;
  logic [THR_W-1:0]       umbral_bajo;
  logic [THR_W-1:0]       umbral_alto;
  logic                   push;
  logic [DATA_W-1:0]      data_out;
  logic                   in_full;
  logic [N-1:0]           pop;
  logic [N-1:0]           almost_full;
  logic [N-1:0]           empty;
  logic [N*DATA_W-1:0]    data_in;
  logic [N-1:0]           valid;
  logic                   done;
  logic                   pass;
  logic                   timeout;
  logic [7:0]             err_cnt;

  tl_traffic_gen #(
    .DATA_W(DATA_W), .CLASS_W(CLASS_W), .CLASS_LSB(CLASS_LSB), .WORDS(WORDS),
    .THR_W(THR_W), .THR_LO0(0), .THR_HI0(7), .THR_LO1(1), .THR_HI1(6),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .init(init),
    .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
    .push(push), .data_out(data_out), .in_full(in_full),
    .pop(pop), .almost_full(almost_full), .empty(empty),
    .data_in(data_in), .valid(valid),
    .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] make_word(input int c, input int s);
    return DATA_W'((c << CLASS_LSB) | s);
  endfunction

  // Modes, written by the main sequence only.
  int af_thr    = 4;
  bit swap12    = 0;
  bit no_valid  = 0;
  bit rand_full = 0;
  int stall_at  = -1;
  int run_id    = 0;

  // Model state, written by the model process only.
  int                seen_id;
  logic [DATA_W-1:0] mem [N][TOTAL];
  int                wr [N];
  int                rd [N];
  int                pops_k [N];
  int                rcv_k [N];
  int                push_idx, pops_total, exp_err;
  bit                prev_in_full, prev_all;
  logic [N-1:0]      prev_af;
  logic [DATA_W-1:0] last_data;
  bit                stall_fired;
  int                stall_left;

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      wr[i] = 0; rd[i] = 0; pops_k[i] = 0; rcv_k[i] = 0;
    end
    push_idx = 0; pops_total = 0; exp_err = 0;
    prev_in_full = 0; prev_all = 0; prev_af = '0; last_data = '0;
    stall_fired = 0; stall_left = 0;
  endfunction

  initial begin : fifo_model
    logic              s_push;
    logic [DATA_W-1:0] s_data;
    logic [N-1:0]      s_pop;
    logic [DATA_W-1:0] w;
    int                k;
    int                c;
    in_full = 1'b0; empty = '1; almost_full = '0; valid = '0; data_in = '0;
    seen_id = 0; k = 0;
    model_clear();
    forever begin
      @(negedge clk);
      s_push = 1'b0; s_data = '0; s_pop = '0;
      if (!reset_L || seen_id != run_id) begin
        seen_id = run_id;
        model_clear();
      end
      if (reset_L) begin
        s_push = push; s_data = data_out; s_pop = pop;
        // Push side: registered push follows in_full of the previous cycle.
        if (prev_in_full) check("push_blocked", push, 0);
        else if (push_idx > 0 && push_idx < TOTAL) check("push_rate", push, 1);
        if (push) begin
          if (push_idx < TOTAL)
            check("push_word", data_out, make_word(push_idx / WORDS, push_idx % WORDS));
          else
            check("push_extra", push, 0);
          push_idx++;
          last_data = data_out;
        end else if (push_idx > 0) begin
          check("data_hold", data_out, last_data);
        end
        // Pop side: eligibility is judged on the previous cycle's flags.
        if (s_pop != '0) begin
          check("pop_onehot", $onehot(s_pop), 1);
          for (int i = N - 1; i >= 0; i--) if (s_pop[i]) k = i;
          check("pop_nonempty", wr[k] > rd[k], 1);
          check("pop_eligible", prev_af[k] || prev_all, 1);
          check("pop_budget", pops_k[k] < WORDS, 1);
          pops_k[k]++;
          pops_total++;
        end
        prev_in_full = in_full;
        prev_af      = almost_full;
        prev_all     = (push_idx == TOTAL);
      end

      @(posedge clk);
      #1;
      if (!reset_L) begin
        model_clear();
        in_full = 1'b0; empty = '1; almost_full = '0; valid = '0;
      end else begin
        valid = '0;
        if (s_pop != '0 && wr[k] > rd[k]) begin
          w = mem[k][rd[k]];
          rd[k]++;
          if (!no_valid) begin
            valid[k] = 1'b1;
            data_in[k*DATA_W +: DATA_W] = w;
            if (w != make_word(k, rcv_k[k])) exp_err++;
            rcv_k[k]++;
          end
        end
        if (s_push) begin
          c = int'(s_data[CLASS_LSB +: CLASS_W]);
          if (swap12 && c == 1)      c = 2;
          else if (swap12 && c == 2) c = 1;
          if (wr[c] < TOTAL) begin
            mem[c][wr[c]] = s_data;
            wr[c]++;
          end
        end
        for (int i = 0; i < N; i++) begin
          empty[i]       = (wr[i] == rd[i]);
          almost_full[i] = ((wr[i] - rd[i]) >= af_thr);
        end
        if (stall_at >= 0 && !stall_fired && push_idx >= stall_at) begin
          stall_fired = 1;
          stall_left  = 10;
        end
        if (stall_left > 0) begin
          in_full = 1'b1;
          stall_left--;
        end else begin
          in_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
      end
    end
  end

  task automatic start_run();
    @(negedge clk); #2;
    run_id++;
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int idle_streak);
    int cyc;
    idle_streak = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done !== 1'b1) begin
        if (push || pop != '0 || valid != '0) idle_streak = 0;
        else idle_streak++;
      end
    end
    check("done_within_budget", done, 1);
  endtask

  task automatic finish_checks(input bit exp_pass, input bit exp_to, input int exp_errs);
    check("pass", pass, exp_pass);
    check("timeout", timeout, exp_to);
    check("err_cnt", err_cnt, exp_errs);
    check("err_cnt_vs_model", err_cnt, exp_err);
    check("push_count", push_idx, TOTAL);
    check("pop_count", pops_total, TOTAL);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int streak;
    reset_L = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {init, push, pop, done, pass, timeout}, 0);
    check("reset_thr", {umbral_bajo, umbral_alto}, 0);
    check("reset_err", err_cnt, 0);
    #2 reset_L = 1'b1;

    // Run aborted by reset mid-push, then a clean restart.
    start_run();
    repeat (12) @(negedge clk);
    check("pre_reset_thr_hi", umbral_alto, 6);
    #2 reset_L = 1'b0;
    #1;
    check("async_reset_ctl", {init, push, pop, done, pass, timeout}, 0);
    check("async_reset_thr", {umbral_bajo, umbral_alto}, 0);
    check("async_reset_data", data_out, 0);
    check("async_reset_err", err_cnt, 0);
    @(negedge clk); @(negedge clk);
    #2 reset_L = 1'b1;
    @(negedge clk); #2;
    run_id++;
    start = 1'b1;
    @(negedge clk);
    check("cfg0_init", init, 1);
    check("cfg0_thr", {umbral_bajo, umbral_alto}, {3'd0, 3'd7});
    #2 start = 1'b0;
    @(negedge clk);
    check("cfg1_init", init, 1);
    check("cfg1_thr", {umbral_bajo, umbral_alto}, {3'd1, 3'd6});
    @(negedge clk);
    check("rel_init", init, 0);
    check("rel_push", push, 0);
    check("rel_thr_hold", {umbral_bajo, umbral_alto}, {3'd1, 3'd6});
    @(negedge clk);
    check("first_push", push, 1);
    check("first_word", data_out, 12'h000);
    wait_done(streak);
    finish_checks(1, 0, 0);

    // Almost-full at depth 3, a 10-cycle input stall, and a stray start.
    af_thr = 3; stall_at = 6;
    start_run();
    repeat (20) @(negedge clk);
    #2 start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
    wait_done(streak);
    finish_checks(1, 0, 0);
    stall_at = -1;

    // Class 1 and 2 outputs swapped: every word of both classes mismatches.
    swap12 = 1; af_thr = 2; rand_full = 1;
    start_run();
    wait_done(streak);
    finish_checks(0, 0, 8);
    swap12 = 0;

    // Randomized thresholds and input back-pressure.
    for (int r = 0; r < 3; r++) begin
      af_thr = int'($urandom_range(1, 4));
      start_run();
      wait_done(streak);
      finish_checks(1, 0, 0);
    end

    // Valid never returned: the run aborts after TIMEOUT idle cycles.
    no_valid = 1; rand_full = 0; af_thr = 2;
    start_run();
    wait_done(streak);
    check("timeout_idle_cycles", streak, TIMEOUT);
    check("timeout_done", done, 1);
    finish_checks(0, 1, 0);
    no_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
